// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES constants and helpers used by the iterative DES core:
//   - FSM state enum
//   - IP, FP, E, P, PC-1 and PC-2 index tables (FIPS 46-3 numbering, 1 = MSB)
//   - per-round key rotation schedule SHIFTS[1:16]
//   - S-box tables S1..S8
//   - permutation and S-box lookup helper functions
// A W-bit vector v[W-1:0] holds FIPS bit n at index W-n.
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_t;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount per encrypt round; element 1 is the leftmost.
  localparam logic [1:16][1:0] SHIFTS = {
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Each box is stored row-major: index = row*16 + col.
  localparam logic [3:0] SBOX [8][64] = '{
    '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
      4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
      4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
      4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
    '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
      4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
      4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
      4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
    '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
      4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
      4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
      4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
    '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
    '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
      4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
      4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
      4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
    '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
      4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
      4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
      4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
    '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
      4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
      4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
      4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
    '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
      4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
      4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
      4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
  };

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
    return y;
  endfunction

  // Row is formed from the outer bits, column from the inner four.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
    return SBOX[box][{six[5], six[0], six[4:1]}];
  endfunction

  // Rotation amount for a round. Decrypt walks the schedule backwards, so
  // round 1 uses C16/D16 (== C0/D0) unrotated and later rounds rotate right.
  function automatic logic [1:0] shift_amt(input logic [4:0] round, input logic dec);
    if (round == 5'd0 || round > 5'd16) return 2'd0;
    if (dec && round == 5'd1)           return 2'd0;
    return SHIFTS[round];
  endfunction

  // Rotate a 28-bit key half; "left" moves bits toward FIPS bit 1 (the MSB).
  function automatic logic [27:0] rot28(input logic [27:0] c, input logic [1:0] amt,
                                        input logic right);
    case (amt)
      2'd1:    return right ? {c[0], c[27:1]}   : {c[26:0], c[27]};
      2'd2:    return right ? {c[1:0], c[27:2]} : {c[25:0], c[27:26]};
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/des_f.sv
// -----------------------------------------------------------------------------
// des_f
// Combinational DES round function f(R, K): expansion E, subkey XOR,
// S-boxes S1..S8 and permutation P.
// Ports:
//   i_r [31:0]  right half R (FIPS bit 1 = MSB)
//   i_k [47:0]  round subkey Ki
//   o_f [31:0]  f(R, Ki)
// -----------------------------------------------------------------------------
module des_f
  import des_pkg::*;
(
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_f
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  assign w_x = perm_e(i_r) ^ i_k;

  // Six-bit groups from the MSB end feed S1 first; S1's nibble lands at the MSB.
  always_comb begin
    // NOTE: every bit of w_s is given a default before the loop so no path
    // leaves it unassigned, which keeps this purely combinational (no latch).
    w_s = '0;
    for (int s = 0; s < 8; s++) begin
      w_s[5'(31 - 4 * s) -: 4] = sbox_lookup(3'(s), w_x[6'(47 - 6 * s) -: 6]);
    end
  end

  assign o_f = perm_p(w_s);

endmodule

// File: rtl/des_iter_core.sv
// -----------------------------------------------------------------------------
// des_iter_core
// Iterative DES block cipher: one Feistel round per clock, 16 rounds per
// block, with on-the-fly key schedule (PC-1, rotations, PC-2) and IP/FP.
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   start     request one block; sampled only in IDLE
//   decrypt   0 = encrypt, 1 = decrypt; sampled with start
//   key_in    64-bit key incl. parity (parity ignored); sampled with start
//   data_in   64-bit input block; sampled with start
//   busy      high while rounds execute
//   done      one-cycle pulse; data_out valid from this cycle on
//   data_out  result block, held until the next done
// Vectors are read as hex values whose leftmost bit is FIPS bit 1.
// -----------------------------------------------------------------------------
module des_iter_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key_in,
  input  logic [64:1] data_in,
  output logic        busy,
  output logic        done,
  output logic [64:1] data_out
);

  state_t      r_state;
  logic [4:0]  r_round;
  logic        r_mode;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic        r_done;
  logic [63:0] r_data_out;

  logic [1:0]  w_amt;
  logic [27:0] w_c_rot;
  logic [27:0] w_d_rot;
  logic [47:0] w_k;
  logic [31:0] w_f;
  logic [31:0] w_r_next;
  logic        w_round_ok;

  // Key schedule for the current round: rotate C/D, then select Ki with PC-2.
  assign w_amt    = shift_amt(r_round, r_mode);
  assign w_c_rot  = rot28(r_c, w_amt, r_mode);
  assign w_d_rot  = rot28(r_d, w_amt, r_mode);
  assign w_k      = perm_pc2({w_c_rot, w_d_rot});

  des_f u_f (
    .i_r (r_r),
    .i_k (w_k),
    .o_f (w_f)
  );

  assign w_r_next   = r_l ^ w_f;
  assign w_round_ok = (r_round >= 5'd1) && (r_round <= 5'd16);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values; L <= R and R <= L^f rely on this.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_round    <= '0;
      r_mode     <= 1'b0;
      r_l        <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_round <= '0;
          if (start) begin
            {r_l, r_r} <= perm_ip(data_in);
            {r_c, r_d} <= perm_pc1(key_in);
            r_mode     <= decrypt;
            r_round    <= 5'd1;
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          if (w_round_ok) begin
            r_l <= r_r;
            r_r <= w_r_next;
            r_c <= w_c_rot;
            r_d <= w_d_rot;
            if (r_round == 5'd16) begin
              // Final round: output is FP of the swapped halves R16 || L16.
              r_data_out <= perm_fp({w_r_next, r_r});
              r_done     <= 1'b1;
              r_round    <= '0;
              r_state    <= IDLE;
            end else begin
              r_round <= r_round + 5'd1;
            end
          end else begin
            r_round <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_round <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state == ROUND);
  assign done     = r_done;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_des_iter_core.sv
// -----------------------------------------------------------------------------
// tb_des_iter_core
// Directed self-checking bench for des_iter_core using known DES vectors.
// -----------------------------------------------------------------------------
module tb_des_iter_core;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2 = 64'h8787878787878787;
  localparam logic [63:0] CT2 = 64'h0000000000000000;
  localparam logic [63:0] PAR = 64'h0101010101010101;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [64:1] key_in;
  logic [64:1] data_in;
  logic        busy;
  logic        done;
  logic [64:1] data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  des_iter_core dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .decrypt  (decrypt),
    .key_in   (key_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one block starting in the current cycle (cycle 0) and checks latency,
  // busy length, result and hold behaviour. With scramble set, inputs are
  // randomised every cycle while the rounds run.
  task automatic run_block(input string name, input logic [63:0] key,
                           input logic [63:0] data, input logic dec,
                           input logic [63:0] exp, input bit scramble);
    int          done_cyc;
    int          busy_cnt;
    logic [63:0] res;
    done_cyc = -1;
    busy_cnt = 0;
    res      = '0;
    key_in   = key;
    data_in  = data;
    decrypt  = dec;
    start    = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      total++;
      if (busy === 1'b1 && done === 1'b1) begin
        bad++;
        $display("FAIL %s busy_done_overlap cycle=%0d", name, k);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cyc = k;
        res      = data_out;
        break;
      end
      if (scramble) begin
        start   = 1'($urandom_range(0, 1));
        decrypt = 1'($urandom_range(0, 1));
        key_in  = {$urandom(), $urandom()};
        data_in = {$urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (done_cyc !== 17) begin
      bad++;
      $display("FAIL %s done_cycle got=%0d want=17", name, done_cyc);
    end
    total++;
    if (busy_cnt !== 16) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=16", name, busy_cnt);
    end
    total++;
    if (res !== exp) begin
      bad++;
      $display("FAIL %s result got=%h want=%h", name, res, exp);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done done=%b busy=%b want 0/0", name, done, busy);
    end
    tick();
    tick();
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s hold got=%h want=%h", name, data_out, exp);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b1;
    decrypt = 1'b0;
    key_in  = K1;
    data_in = PT1;
    tick();
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 64'h0) begin
      bad++;
      $display("FAIL reset_state busy=%b done=%b data_out=%h want 0/0/0", busy, done, data_out);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release busy=%b want 0", busy);
    end
  endtask

  task automatic test_encrypt();
    run_block("encrypt_k1", K1, PT1, 1'b0, CT1, 1'b0);
  endtask

  task automatic test_decrypt();
    run_block("decrypt_k1", K1, CT1, 1'b1, PT1, 1'b0);
    run_block("encrypt_k2", K2, PT2, 1'b0, CT2, 1'b0);
    run_block("decrypt_k2", K2, CT2, 1'b1, PT2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int          n_done;
    int          d1;
    int          d2;
    logic [63:0] r1;
    logic [63:0] r2;
    n_done  = 0;
    d1      = -1;
    d2      = -1;
    r1      = '0;
    r2      = '0;
    key_in  = K1;
    data_in = PT1;
    decrypt = 1'b0;
    start   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (d1 < 0) begin
          d1 = k;
          r1 = data_out;
        end else if (d2 < 0) begin
          d2 = k;
          r2 = data_out;
        end
      end
      // Cycles 5 and 12 carry stray requests; cycle 17 is the real second one.
      start   = (k == 5 || k == 12 || k == 17);
      decrypt = (k == 5 || k == 12 || k == 17);
      key_in  = (k == 5 || k == 12) ? K2 : K1;
      data_in = (k == 17) ? CT1 : PT2;
    end
    start = 1'b0;
    total++;
    if (d1 !== 17 || d2 !== 34) begin
      bad++;
      $display("FAIL b2b_done_cycles got=%0d,%0d want=17,34", d1, d2);
    end
    total++;
    if (r1 !== CT1) begin
      bad++;
      $display("FAIL b2b_first got=%h want=%h", r1, CT1);
    end
    total++;
    if (r2 !== PT1) begin
      bad++;
      $display("FAIL b2b_second got=%h want=%h", r2, PT1);
    end
    total++;
    if (n_done !== 2) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d want=2", n_done);
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    int n_busy;
    n_done  = 0;
    n_busy  = 0;
    key_in  = K1;
    data_in = PT1;
    decrypt = 1'b0;
    start   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start = 1'b0;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_busy_before got=%b want=1", busy);
    end
    // Reset asserted in cycle 8 together with a start request.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 64'h0) begin
      bad++;
      $display("FAIL rst_mid_cycle9 busy=%b done=%b data_out=%h want 0/0/0", busy, done, data_out);
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    total++;
    if (n_done !== 0 || n_busy !== 0) begin
      bad++;
      $display("FAIL rst_mid_quiet dones=%0d busy_cycles=%0d want 0/0", n_done, n_busy);
    end
    total++;
    if (data_out !== 64'h0) begin
      bad++;
      $display("FAIL rst_mid_data_out got=%h want=0", data_out);
    end
    run_block("after_reset", K1, PT1, 1'b0, CT1, 1'b0);
  endtask

  task automatic test_input_stability();
    run_block("scrambled_enc", K1, PT1, 1'b0, CT1, 1'b1);
    run_block("scrambled_dec", K2, CT2, 1'b1, PT2, 1'b1);
  endtask

  task automatic test_parity();
    run_block("parity_flip", K1 ^ PAR, PT1, 1'b0, CT1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_reset_mid();
    test_input_stability();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
